// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer execution stage.
// RV32I ops finish in one cycle, RV32M multiplies run through a short pipe.
// All results are merged into an in-order writeback FIFO and broadcast one per cycle.
module alu_exec_unit #(
    parameter int ROB_ADDR   = 4,   // RoB tag width
    parameter int WB_DEPTH   = 4,   // writeback FIFO entries (>= 4)
    parameter int MUL_STAGES = 3    // multiply latency to FIFO push + 1 (>= 2)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                alu_clear,
    input  logic [5:0]          alu_op,
    input  logic [31:0]         alu_rs1,
    input  logic [31:0]         alu_rs2,
    input  logic [ROB_ADDR-1:0] alu_id,
    output logic                alu_stall,
    output logic                alu_valid,
    output logic [ROB_ADDR-1:0] alu_robid,
    output logic [31:0]         alu_val
);

    // Op encoding shared with the reservation station decoder (0 = bubble).
    localparam logic [5:0] OP_ADD    = 6'd1;
    localparam logic [5:0] OP_SUB    = 6'd2;
    localparam logic [5:0] OP_AND    = 6'd3;
    localparam logic [5:0] OP_OR     = 6'd4;
    localparam logic [5:0] OP_XOR    = 6'd5;
    localparam logic [5:0] OP_SLL    = 6'd6;
    localparam logic [5:0] OP_SRL    = 6'd7;
    localparam logic [5:0] OP_SRA    = 6'd8;
    localparam logic [5:0] OP_SLT    = 6'd9;
    localparam logic [5:0] OP_SLTU   = 6'd10;
    localparam logic [5:0] OP_LUI    = 6'd11;
    localparam logic [5:0] OP_AUIPC  = 6'd12;
    localparam logic [5:0] OP_BEQ    = 6'd13;
    localparam logic [5:0] OP_BNE    = 6'd14;
    localparam logic [5:0] OP_BLT    = 6'd15;
    localparam logic [5:0] OP_BGE    = 6'd16;
    localparam logic [5:0] OP_BLTU   = 6'd17;
    localparam logic [5:0] OP_BGEU   = 6'd18;
    localparam logic [5:0] OP_MUL    = 6'd19;
    localparam logic [5:0] OP_MULH   = 6'd20;
    localparam logic [5:0] OP_MULHSU = 6'd21;
    localparam logic [5:0] OP_MULHU  = 6'd22;

    localparam int MS = MUL_STAGES - 1;                          // pipe registers before the FIFO
    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;   // FIFO pointer width
    localparam int CW = $clog2(WB_DEPTH + 1);                    // occupancy counter width

    // Pointer increment with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(WB_DEPTH - 1)) return '0;
        return p + PW'(1);
    endfunction

    logic                is_mul, accept, mul_start, simple_push, mul_push, pop;
    logic [31:0]         simple_res, mul_res;
    logic [63:0]         mul_a, mul_b, mul_prod;
    logic [5:0]          shamt_unused_guard;

    // Multiply pipe: stage_* is the input of register i (index MS is the pipe tail).
    logic [MS-1:0]       mul_vld_q;
    logic [ROB_ADDR-1:0] mul_id_q  [MS];
    logic [31:0]         mul_res_q [MS];
    logic [MS:0]         stage_vld;
    logic [ROB_ADDR-1:0] stage_id  [MS+1];
    logic [31:0]         stage_res [MS+1];

    // Writeback FIFO and bookkeeping.
    logic [ROB_ADDR-1:0] fifo_id_q  [WB_DEPTH];
    logic [31:0]         fifo_val_q [WB_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, simple_slot;
    logic [CW-1:0]       count_q, count_d, reserved_q, reserved_d;
    logic                stall_q, stall_d, valid_q, valid_d;
    logic [ROB_ADDR-1:0] robid_q, robid_d;
    logic [31:0]         val_q, val_d;

    assign shamt_unused_guard = {1'b0, alu_rs2[4:0]};

    assign is_mul      = (alu_op >= OP_MUL) && (alu_op <= OP_MULHU);
    // A full unit drops the op; a compliant RS never gets here thanks to alu_stall.
    assign accept      = rdy_in && !alu_clear && (alu_op != 6'd0) && (reserved_q < CW'(WB_DEPTH));
    assign mul_start   = accept && is_mul;
    assign simple_push = accept && !is_mul;
    assign mul_push    = rdy_in && !alu_clear && stage_vld[MS];
    assign pop         = rdy_in && !alu_clear && (count_q != '0);
    // The completing multiply is older, so it claims the first free slot.
    assign simple_slot = mul_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    // Single-cycle integer results, including branch compares (1 = taken).
    always_comb begin
        simple_res = '0;
        case (alu_op)
            OP_ADD:   simple_res = alu_rs1 + alu_rs2;
            OP_SUB:   simple_res = alu_rs1 - alu_rs2;
            OP_AND:   simple_res = alu_rs1 & alu_rs2;
            OP_OR:    simple_res = alu_rs1 | alu_rs2;
            OP_XOR:   simple_res = alu_rs1 ^ alu_rs2;
            OP_SLL:   simple_res = alu_rs1 << shamt_unused_guard[4:0];
            OP_SRL:   simple_res = alu_rs1 >> shamt_unused_guard[4:0];
            OP_SRA:   simple_res = $signed(alu_rs1) >>> shamt_unused_guard[4:0];
            OP_SLT:   simple_res = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
            OP_SLTU:  simple_res = {31'd0, alu_rs1 < alu_rs2};
            OP_LUI,
            OP_AUIPC: simple_res = alu_rs2;   // immediate / pc+imm formed upstream
            OP_BEQ:   simple_res = {31'd0, alu_rs1 == alu_rs2};
            OP_BNE:   simple_res = {31'd0, alu_rs1 != alu_rs2};
            OP_BLT:   simple_res = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
            OP_BGE:   simple_res = {31'd0, $signed(alu_rs1) >= $signed(alu_rs2)};
            OP_BLTU:  simple_res = {31'd0, alu_rs1 < alu_rs2};
            OP_BGEU:  simple_res = {31'd0, alu_rs1 >= alu_rs2};
            default:  simple_res = '0;
        endcase
    end

    // Multiply operands are sign- or zero-extended to 64 bits; the low 64 product bits
    // are then exact for every signedness mix. The pipe registers behind it let synthesis
    // retime the multiplier into DSP pipeline stages.
    always_comb begin
        mul_a    = {{32{((alu_op == OP_MULH) || (alu_op == OP_MULHSU)) & alu_rs1[31]}}, alu_rs1};
        mul_b    = {{32{(alu_op == OP_MULH) & alu_rs2[31]}}, alu_rs2};
        mul_prod = mul_a * mul_b;
        mul_res  = (alu_op == OP_MUL) ? mul_prod[31:0] : mul_prod[63:32];
    end

    assign stage_vld[0] = mul_start;
    assign stage_id[0]  = alu_id;
    assign stage_res[0] = mul_res;
    for (genvar gi = 0; gi < MS; gi++) begin : g_stage_link
        assign stage_vld[gi+1] = mul_vld_q[gi];
        assign stage_id[gi+1]  = mul_id_q[gi];
        assign stage_res[gi+1] = mul_res_q[gi];
    end

    // Next-state for FIFO pointers, occupancy, stall and the broadcast registers.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reserved_d = reserved_q;
        if (alu_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            reserved_d = '0;
        end else begin
            if (mul_push)    wr_ptr_d = ptr_inc(wr_ptr_d);
            if (simple_push) wr_ptr_d = ptr_inc(wr_ptr_d);
            if (pop)         rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d    = count_q + CW'(mul_push) + CW'(simple_push) - CW'(pop);
            reserved_d = reserved_q + CW'(accept) - CW'(pop);
        end
        // Two slots of slack: one for the op RS may already have launched.
        stall_d = (reserved_d >= CW'(WB_DEPTH - 2));
        valid_d = pop;
        robid_d = pop ? fifo_id_q[rd_ptr_q]  : '0;
        val_d   = pop ? fifo_val_q[rd_ptr_q] : '0;
    end

    // Control state: async reset, frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            mul_vld_q  <= '0;
            for (int i = 0; i < MS; i++) mul_id_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            stall_q    <= 1'b0;
            valid_q    <= 1'b0;
            robid_q    <= '0;
            val_q      <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < MS; i++) begin
                mul_vld_q[i] <= stage_vld[i] && !alu_clear;
                mul_id_q[i]  <= stage_id[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
            stall_q    <= stall_d;
            valid_q    <= valid_d;
            robid_q    <= robid_d;
            val_q      <= val_d;
        end
    end

    // Multiply result data path; qualified by mul_vld_q so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int i = 0; i < MS; i++) mul_res_q[i] <= stage_res[i];
        end
    end

    // FIFO storage: up to two writes per edge at consecutive slots.
    always_ff @(posedge clk_in) begin
        if (mul_push) begin
            fifo_id_q[wr_ptr_q]  <= stage_id[MS];
            fifo_val_q[wr_ptr_q] <= stage_res[MS];
        end
        if (simple_push) begin
            fifo_id_q[simple_slot]  <= alu_id;
            fifo_val_q[simple_slot] <= simple_res;
        end
    end

    assign alu_stall = stall_q;
    assign alu_valid = valid_q;
    assign alu_robid = robid_q;
    assign alu_val   = val_q;

    // Issuing into a full unit loses the op; flag it loudly in simulation.
    a_no_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
        !(rdy_in && !alu_clear && (alu_op != 6'd0) && (reserved_q >= CW'(WB_DEPTH))));

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit plus hand-written multi-cycle sequences.
module tb_alu_exec_unit;
    localparam int ROB_ADDR   = 4;
    localparam int WB_DEPTH   = 4;
    localparam int MUL_STAGES = 3;

    localparam logic [5:0] OP_ADD = 6'd1,  OP_SUB = 6'd2,  OP_AND = 6'd3,  OP_OR = 6'd4;
    localparam logic [5:0] OP_XOR = 6'd5,  OP_SLL = 6'd6,  OP_SRL = 6'd7,  OP_SRA = 6'd8;
    localparam logic [5:0] OP_SLT = 6'd9,  OP_SLTU = 6'd10, OP_LUI = 6'd11, OP_AUIPC = 6'd12;
    localparam logic [5:0] OP_BEQ = 6'd13, OP_BNE = 6'd14, OP_BLT = 6'd15, OP_BGE = 6'd16;
    localparam logic [5:0] OP_BLTU = 6'd17, OP_BGEU = 6'd18, OP_MUL = 6'd19, OP_MULH = 6'd20;
    localparam logic [5:0] OP_MULHSU = 6'd21, OP_MULHU = 6'd22;

    logic                clk_in = 1'b0;
    logic                rst_in, rdy_in, alu_clear;
    logic [5:0]          alu_op;
    logic [31:0]         alu_rs1, alu_rs2;
    logic [ROB_ADDR-1:0] alu_id;
    logic                alu_stall, alu_valid;
    logic [ROB_ADDR-1:0] alu_robid;
    logic [31:0]         alu_val;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    alu_exec_unit #(.ROB_ADDR(ROB_ADDR), .WB_DEPTH(WB_DEPTH), .MUL_STAGES(MUL_STAGES)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .alu_clear(alu_clear),
        .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_id(alu_id),
        .alu_stall(alu_stall), .alu_valid(alu_valid), .alu_robid(alu_robid), .alu_val(alu_val)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  id;
        logic [31:0] exp_val;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] id, input logic [31:0] ev, input int lat);
        vec_t v;
        v.op = op; v.rs1 = a; v.rs2 = b; v.id = id; v.exp_val = ev; v.exp_lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] id);
        alu_op = op; alu_rs1 = a; alu_rs2 = b; alu_id = id;
    endtask

    task automatic bubble();
        drive(6'd0, 32'd0, 32'd0, 4'd0);
    endtask

    // Steps until alu_valid or the budget runs out; lat = edges taken (budget+1 on timeout).
    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (lat < budget) begin
            step();
            lat++;
            if (alu_valid) return;
        end
        lat = budget + 1;
    endtask

    initial begin
        int lat, got, hits;
        logic [31:0] exp_q[$];
        logic [3:0]  exp_id_q[$];

        rst_in = 1'b0; rdy_in = 1'b1; alu_clear = 1'b0;
        bubble();
        #1;
        check("reset_valid", {31'd0, alu_valid}, 32'd0);
        check("reset_robid", {28'd0, alu_robid}, 32'd0);
        check("reset_val",   alu_val, 32'd0);
        check("reset_stall", {31'd0, alu_stall}, 32'd0);
        step(); step();
        #2 rst_in = 1'b1;
        step();

        // ---------------- table-driven single ops ----------------
        vecs.push_back(mk(OP_ADD,    32'd5,        32'd7,        4'd3,  32'd12,        1));
        vecs.push_back(mk(OP_SUB,    32'd0,        32'd1,        4'd1,  32'hFFFFFFFF,  1));
        vecs.push_back(mk(OP_SRA,    32'h80000000, 32'd4,        4'd2,  32'hF8000000,  1));
        vecs.push_back(mk(OP_SRL,    32'h80000000, 32'd4,        4'd4,  32'h08000000,  1));
        vecs.push_back(mk(OP_SLL,    32'd1,        32'h23,       4'd5,  32'd8,         1));
        vecs.push_back(mk(OP_AND,    32'hF0F0F0F0, 32'h0FF00FF0, 4'd6,  32'h00F000F0,  1));
        vecs.push_back(mk(OP_OR,     32'h000000F0, 32'h0000000F, 4'd7,  32'h000000FF,  1));
        vecs.push_back(mk(OP_XOR,    32'hFFFF0000, 32'h0F0F0F0F, 4'd8,  32'hF0F00F0F,  1));
        vecs.push_back(mk(OP_SLT,    32'hFFFFFFFF, 32'd1,        4'd9,  32'd1,         1));
        vecs.push_back(mk(OP_SLTU,   32'hFFFFFFFF, 32'd1,        4'd10, 32'd0,         1));
        vecs.push_back(mk(OP_LUI,    32'd0,        32'h12345000, 4'd11, 32'h12345000,  1));
        vecs.push_back(mk(OP_AUIPC,  32'd0,        32'h00401000, 4'd12, 32'h00401000,  1));
        vecs.push_back(mk(OP_BEQ,    32'd9,        32'd9,        4'd13, 32'd1,         1));
        vecs.push_back(mk(OP_BNE,    32'd9,        32'd9,        4'd14, 32'd0,         1));
        vecs.push_back(mk(OP_BLT,    32'h80000000, 32'd0,        4'd15, 32'd1,         1));
        vecs.push_back(mk(OP_BGE,    32'h80000000, 32'd0,        4'd0,  32'd0,         1));
        vecs.push_back(mk(OP_BLTU,   32'h80000000, 32'd0,        4'd1,  32'd0,         1));
        vecs.push_back(mk(OP_BGEU,   32'h80000000, 32'd0,        4'd2,  32'd1,         1));
        vecs.push_back(mk(OP_MUL,    32'hFFFFFFFF, 32'd3,        4'd3,  32'hFFFFFFFD,  MUL_STAGES));
        vecs.push_back(mk(OP_MULH,   32'h80000000, 32'h80000000, 4'd4,  32'h40000000,  MUL_STAGES));
        vecs.push_back(mk(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'd5,  32'h00000000,  MUL_STAGES));
        vecs.push_back(mk(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd6,  32'hFFFFFFFF,  MUL_STAGES));
        vecs.push_back(mk(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd7,  32'hFFFFFFFE,  MUL_STAGES));

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].id);
            step();
            bubble();
            wait_valid(8, lat);
            $display("vec %0d op=%0d rs1=%08h rs2=%08h -> id=%0d val=%08h lat=%0d",
                     i, vecs[i].op, vecs[i].rs1, vecs[i].rs2, alu_robid, alu_val, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_robid", i), {28'd0, alu_robid}, {28'd0, vecs[i].id});
            check($sformatf("vec%0d_val", i), alu_val, vecs[i].exp_val);
            step();
            check($sformatf("vec%0d_single_cycle", i), {31'd0, alu_valid}, 32'd0);
        end

        // ---------------- back-to-back SUB then SRA ----------------
        drive(OP_SUB, 32'd0, 32'd1, 4'd1); step();
        drive(OP_SRA, 32'h80000000, 32'd4, 4'd2); step();
        bubble();
        $display("b2b first: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("b2b_first_valid", {31'd0, alu_valid}, 32'd1);
        check("b2b_first_val", alu_val, 32'hFFFFFFFF);
        step();
        $display("b2b second: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("b2b_second_valid", {31'd0, alu_valid}, 32'd1);
        check("b2b_second_id", {28'd0, alu_robid}, 32'd2);
        check("b2b_second_val", alu_val, 32'hF8000000);
        step();
        check("b2b_idle", {31'd0, alu_valid}, 32'd0);

        // ---------------- MULHU then ADD one edge later: ADD overtakes ----------------
        drive(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1); step();
        drive(OP_ADD, 32'd1, 32'd1, 4'd2); step();
        bubble(); step();
        $display("ooo first: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("ooo_first_id", {28'd0, alu_robid}, 32'd2);
        check("ooo_first_val", alu_val, 32'd2);
        step();
        $display("ooo second: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("ooo_second_valid", {31'd0, alu_valid}, 32'd1);
        check("ooo_second_id", {28'd0, alu_robid}, 32'd1);
        check("ooo_second_val", alu_val, 32'hFFFFFFFE);
        step();

        // ---------------- MULHU edge0, ADD edge2: same-edge push, mul takes lower slot ----------------
        drive(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd1); step();
        bubble(); step();
        drive(OP_ADD, 32'd1, 32'd1, 4'd2); step();
        bubble();
        check("tie_pre_valid", {31'd0, alu_valid}, 32'd0);
        step();
        $display("tie first: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("tie_first_id", {28'd0, alu_robid}, 32'd1);
        check("tie_first_val", alu_val, 32'hFFFFFFFE);
        step();
        $display("tie second: valid=%0d id=%0d val=%08h", alu_valid, alu_robid, alu_val);
        check("tie_second_id", {28'd0, alu_robid}, 32'd2);
        check("tie_second_val", alu_val, 32'd2);
        step();

        // ---------------- 4 MULs from a stall-respecting issuer ----------------
        got = 0;
        begin
            int issued = 0;
            for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
                if (issued < 4 && !alu_stall) begin
                    drive(OP_MUL, 32'(issued + 2), 32'(issued + 3), 4'(4 + issued));
                    exp_q.push_back(32'((issued + 2) * (issued + 3)));
                    exp_id_q.push_back(4'(4 + issued));
                    issued++;
                end else begin
                    bubble();
                end
                step();
                if (cyc == 0) check("stall_after_1_mul", {31'd0, alu_stall}, 32'd0);
                if (cyc == 1) check("stall_after_2_mul", {31'd0, alu_stall}, 32'd1);
                if (alu_valid) begin
                    $display("stall seq result: id=%0d val=%08h stall=%0d", alu_robid, alu_val, alu_stall);
                    if (exp_q.size() == 0) begin
                        check("stall_unexpected_result", {31'd0, alu_valid}, 32'd0);
                    end else begin
                        check($sformatf("stall_res%0d_id", got), {28'd0, alu_robid}, {28'd0, exp_id_q.pop_front()});
                        check($sformatf("stall_res%0d_val", got), alu_val, exp_q.pop_front());
                    end
                    got++;
                end
            end
        end
        bubble();
        check("stall_result_count", got, 32'd4);
        step();
        check("stall_released", {31'd0, alu_stall}, 32'd0);

        // ---------------- flush with 2 MULs in flight and 1 result queued ----------------
        drive(OP_MUL, 32'd2, 32'd2, 4'd1); step();
        drive(OP_MUL, 32'd3, 32'd3, 4'd2); step();
        drive(OP_MUL, 32'd4, 32'd4, 4'd3); step();
        drive(OP_ADD, 32'd1, 32'd1, 4'd4); alu_clear = 1'b1; step();
        alu_clear = 1'b0; bubble();
        $display("clear: valid=%0d stall=%0d", alu_valid, alu_stall);
        check("clear_valid", {31'd0, alu_valid}, 32'd0);
        check("clear_stall", {31'd0, alu_stall}, 32'd0);
        hits = 0;
        for (int k = 0; k < 8; k++) begin step(); if (alu_valid) hits++; end
        check("clear_no_results", hits, 32'd0);
        drive(OP_ADD, 32'd20, 32'd22, 4'd9); step(); bubble();
        wait_valid(4, lat);
        $display("post-clear add: id=%0d val=%08h lat=%0d", alu_robid, alu_val, lat);
        check("post_clear_lat", lat, 32'd1);
        check("post_clear_val", alu_val, 32'd42);
        step();

        // ---------------- rdy_in low for 3 edges with BEQ held ----------------
        rdy_in = 1'b0;
        drive(OP_BEQ, 32'd9, 32'd9, 4'd7);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("rdy_low_valid%0d", k), {31'd0, alu_valid}, 32'd0);
        end
        rdy_in = 1'b1; step(); bubble();
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (alu_valid) begin
                hits++;
                $display("rdy seq result: id=%0d val=%08h", alu_robid, alu_val);
                check("rdy_result_id", {28'd0, alu_robid}, 32'd7);
                check("rdy_result_val", alu_val, 32'd1);
            end
        end
        check("rdy_result_count", hits, 32'd1);

        // ---------------- async reset mid-multiply ----------------
        drive(OP_MUL, 32'd5, 32'd5, 4'd2); step();
        drive(OP_ADD, 32'd3, 32'd4, 4'd3); step();
        bubble(); step();
        check("pre_rst_valid", {31'd0, alu_valid}, 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, alu_valid}, 32'd0);
        check("async_rst_val", alu_val, 32'd0);
        step();
        #2 rst_in = 1'b1;
        hits = 0;
        for (int k = 0; k < 8; k++) begin step(); if (alu_valid) hits++; end
        $display("after reset: %0d results seen", hits);
        check("rst_no_results", hits, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
